// File: rtl/pc_stack_pkg.sv
// pc_stack_pkg: action encodings and the priority decoder shared by the PC/stack slice.
package pc_stack_pkg;

    typedef enum logic [2:0] {
        ACT_IDLE,
        ACT_LOAD,
        ACT_REL,
        ACT_CALL,
        ACT_RET,
        ACT_INC
    } action_t;

    function automatic action_t decode_action(
        input logic load,
        input logic rel,
        input logic call,
        input logic ret,
        input logic inc
    );
        return load ? ACT_LOAD :
               rel  ? ACT_REL  :
               call ? ACT_CALL :
               ret  ? ACT_RET  :
               inc  ? ACT_INC  : ACT_IDLE;
    endfunction

endpackage

// File: rtl/pc_stack_ret_stack.sv
// ret_stack: LIFO of return addresses with combinational top-of-stack read.
module ret_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           top,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int IW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    assign full  = count == CW'(DEPTH);
    assign empty = count == '0;
    assign top   = mem[IW'(count - 1'b1)];

    always_ff @(posedge clk) begin
        if (!reset)
            count <= '0;
        else if (push && !full)
            count <= count + 1'b1;
        else if (pop && !empty)
            count <= count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset && push && !full)
            mem[IW'(count)] <= din;
    end

endmodule

// File: rtl/pc_stack.sv
// pc_stack: program counter with relative branch and call/return through a hardware stack.
module pc_stack
    import pc_stack_pkg::*;
#(
    parameter int               WIDTH      = 16,
    parameter int               STEP       = 1,
    parameter int               DEPTH      = 8,
    parameter logic [WIDTH-1:0] RESET_ADDR = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           in,
    input  logic [WIDTH-1:0]           offset,
    input  logic                       load,
    input  logic                       rel,
    input  logic                       call,
    input  logic                       ret,
    input  logic                       inc,
    output logic [WIDTH-1:0]           out,
    output logic [$clog2(DEPTH+1)-1:0] sp,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    output logic                       underflow
);
    action_t          act;
    logic [WIDTH-1:0] next_pc;
    logic [WIDTH-1:0] step_pc;
    logic [WIDTH-1:0] top;
    logic             push;
    logic             pop;

    assign act     = decode_action(load, rel, call, ret, inc);
    assign step_pc = out + WIDTH'(STEP);
    assign push    = act == ACT_CALL && !full;
    assign pop     = act == ACT_RET && !empty;

    always_comb begin
        next_pc = (act == ACT_LOAD || act == ACT_CALL) ? in :
                  act == ACT_REL ? out + offset :
                  act == ACT_RET ? (empty ? out : top) :
                  act == ACT_INC ? step_pc : out;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            out       <= RESET_ADDR;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            out <= next_pc;
            if (act == ACT_CALL && full)
                overflow <= 1'b1;
            if (act == ACT_RET && empty)
                underflow <= 1'b1;
        end
    end

    ret_stack #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_ret_stack (
        .clk  (clk),
        .reset(reset),
        .push (push),
        .pop  (pop),
        .din  (step_pc),
        .top  (top),
        .count(sp),
        .full (full),
        .empty(empty)
    );

endmodule
